// File: rtl/rs.sv
// Unified 16-entry reservation station (LOAD 0-2, STORE 3-5, ALU 6-15) for a 3-wide OoO core.
// Optional: define RS_CDB_BYPASS_EN to capture a same-cycle CDB broadcast at dispatch.
`ifndef ROB_SIZE
`define ROB_SIZE 16
`endif
`ifndef RV32_LOAD
`define RV32_LOAD 7'b0000011
`endif
`ifndef RV32_STORE
`define RV32_STORE 7'b0100011
`endif

package rs_pkg;
  localparam int ROB_SIZE  = `ROB_SIZE;
  localparam int TW        = $clog2(ROB_SIZE);
  localparam int RS_SIZE   = 16;
  localparam int IW        = $clog2(RS_SIZE);
  localparam int NUM_LANES = 3;
  localparam int STORE_LO  = 3;
  localparam int ALU_LO    = 6;

  localparam logic [1:0] CLS_LOAD  = 2'd0;
  localparam logic [1:0] CLS_STORE = 2'd1;
  localparam logic [1:0] CLS_ALU   = 2'd2;

  typedef struct packed {
    logic          busy;
    logic          issued;
    logic [6:0]    opcode;
    logic [TW-1:0] T;
    logic [TW-1:0] T1;
    logic [TW-1:0] T2;
    logic [31:0]   V1;
    logic [31:0]   V2;
  } RS_ENTRY;

  function automatic logic [1:0] op_class(input logic [6:0] op);
    if (op == `RV32_LOAD)  return CLS_LOAD;
    if (op == `RV32_STORE) return CLS_STORE;
    return CLS_ALU;
  endfunction

  function automatic logic [1:0] ent_class(input int e);
    if (e < STORE_LO) return CLS_LOAD;
    if (e < ALU_LO)   return CLS_STORE;
    return CLS_ALU;
  endfunction
endpackage

// Per-entry next-state: issue mark, CDB wakeup, execute free, dispatch write.
module rs_ent
  import rs_pkg::*;
(
  input  RS_ENTRY                         ent_q,
  input  logic                            issue_set,
  input  logic                            complete_en,
  input  logic [NUM_LANES-1:0][TW-1:0]    cdb_tag,
  input  logic [NUM_LANES-1:0][31:0]      cdb_value,
  input  logic                            execute_en,
  input  logic [NUM_LANES-1:0][TW-1:0]    execute_rob_tag,
  input  logic                            wr_en,
  input  RS_ENTRY                         wr_ent,
  output RS_ENTRY                         ent_d
);
  logic hit1, hit2, kill;

  always_comb begin
    ent_d = ent_q;
    hit1  = 1'b0;
    hit2  = 1'b0;
    kill  = 1'b0;
    if (issue_set) ent_d.issued = 1'b1;
    // Ascending scan with a hit flag: the lowest CDB lane wins on duplicate tags.
    if (complete_en && ent_q.busy) begin
      for (int j = 0; j < NUM_LANES; j++) begin
        if (!hit1 && ent_q.T1 != '0 && ent_q.T1 == cdb_tag[j]) begin
          hit1     = 1'b1;
          ent_d.V1 = cdb_value[j];
          ent_d.T1 = '0;
        end
        if (!hit2 && ent_q.T2 != '0 && ent_q.T2 == cdb_tag[j]) begin
          hit2     = 1'b1;
          ent_d.V2 = cdb_value[j];
          ent_d.T2 = '0;
        end
      end
    end
    if (execute_en && ent_q.busy) begin
      for (int j = 0; j < NUM_LANES; j++)
        if (execute_rob_tag[j] != '0 && execute_rob_tag[j] == ent_q.T) kill = 1'b1;
    end
    if (kill)  ent_d = '0;
    if (wr_en) ent_d = wr_ent;
  end
endmodule

module rs
  import rs_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               dispatch_en,
  input  logic [NUM_LANES-1:0][6:0]          opcode,
  input  logic [TW-1:0]                      ROB_tail,
  input  logic [NUM_LANES-1:0][TW-1:0]       MAP_TABLE_tag1,
  input  logic [NUM_LANES-1:0][TW-1:0]       MAP_TABLE_tag2,
  input  logic [NUM_LANES-1:0]               MAP_TABLE_ready1,
  input  logic [NUM_LANES-1:0]               MAP_TABLE_ready2,
  input  logic [NUM_LANES-1:0]               MAP_TABLE_hit1,
  input  logic [NUM_LANES-1:0]               MAP_TABLE_hit2,
  input  logic [NUM_LANES-1:0][31:0]         OPA,
  input  logic [NUM_LANES-1:0][31:0]         OPB,
  input  logic [NUM_LANES-1:0][31:0]         ROB_V1,
  input  logic [NUM_LANES-1:0][31:0]         ROB_V2,
  input  logic                               issue_en,
  input  logic                               execute_en,
  input  logic [NUM_LANES-1:0][TW-1:0]       execute_rob_tag,
  input  logic                               complete_en,
  input  logic [NUM_LANES-1:0][TW-1:0]       CDB_tag,
  input  logic [NUM_LANES-1:0][31:0]         CDB_value,
  output logic [2:0]                         RS_available_size,
  output logic [NUM_LANES-1:0][4:0]          RS_idx_test,
  output logic [NUM_LANES-1:0]               permit_issue,
  output logic [NUM_LANES-1:0][31:0]         issue_V1_out,
  output logic [NUM_LANES-1:0][31:0]         issue_V2_out,
  output RS_ENTRY [RS_SIZE-1:0]              rs_entry_test
);
  RS_ENTRY [RS_SIZE-1:0]        ent_q, ent_d, wr_ent;
  logic    [RS_SIZE-1:0]        wr_en, taken, issue_sel;
  logic    [NUM_LANES-1:0][IW-1:0] alloc_sel;
  logic    [NUM_LANES-1:0]      alloc_ok;
  logic    [2:0]                avail_cnt;
  logic                         chain, found;
  logic    [IW-1:0]             sel;
  RS_ENTRY [NUM_LANES-1:0]      disp;

  // Wraps mod ROB_SIZE and skips the reserved tag 0.
  function automatic logic [TW-1:0] dispatch_tag(input logic [TW-1:0] tail, input int i);
    logic [TW+1:0] s;
    s = {2'b00, tail} + (TW+2)'(i + 1);
    if (s >= (TW+2)'(ROB_SIZE)) s = s - (TW+2)'(ROB_SIZE);
    if (s == '0) s = (TW+2)'(1);
    return s[TW-1:0];
  endfunction

  function automatic logic [32+TW-1:0] capture(input logic hit, input logic ready,
                                               input logic [TW-1:0] tag,
                                               input logic [31:0] arch_v, input logic [31:0] rob_v);
    if (!hit)  return {arch_v, {TW{1'b0}}};
    if (ready) return {rob_v, {TW{1'b0}}};
    return {32'd0, tag};
  endfunction

  // Allocation: lanes in order, each takes the lowest free entry of its class.
  always_comb begin
    taken     = '0;
    alloc_sel = '0;
    alloc_ok  = '0;
    avail_cnt = '0;
    chain     = 1'b1;
    found     = 1'b0;
    sel       = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      found = 1'b0;
      sel   = '0;
      for (int e = 0; e < RS_SIZE; e++) begin
        if (!found && ent_class(e) == op_class(opcode[i]) && !ent_q[e].busy && !taken[e]) begin
          found = 1'b1;
          sel   = IW'(e);
        end
      end
      if (chain && found) begin
        taken[sel]   = 1'b1;
        alloc_sel[i] = sel;
        alloc_ok[i]  = 1'b1;
        avail_cnt    = avail_cnt + 3'd1;
      end else begin
        chain = 1'b0;
      end
    end
  end

  always_comb begin
    disp = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      disp[i].busy   = 1'b1;
      disp[i].opcode = opcode[i];
      disp[i].T      = dispatch_tag(ROB_tail, i);
      {disp[i].V1, disp[i].T1} = capture(MAP_TABLE_hit1[i], MAP_TABLE_ready1[i],
                                         MAP_TABLE_tag1[i], OPA[i], ROB_V1[i]);
      {disp[i].V2, disp[i].T2} = capture(MAP_TABLE_hit2[i], MAP_TABLE_ready2[i],
                                         MAP_TABLE_tag2[i], OPB[i], ROB_V2[i]);
`ifdef RS_CDB_BYPASS_EN
      // Once a tag is cleared no later lane can match, so lane 0 has priority.
      for (int j = 0; j < NUM_LANES; j++) begin
        if (complete_en && CDB_tag[j] != '0 && disp[i].T1 == CDB_tag[j]) begin
          disp[i].V1 = CDB_value[j];
          disp[i].T1 = '0;
        end
        if (complete_en && CDB_tag[j] != '0 && disp[i].T2 == CDB_tag[j]) begin
          disp[i].V2 = CDB_value[j];
          disp[i].T2 = '0;
        end
      end
`endif
    end
  end

  always_comb begin
    wr_en  = '0;
    wr_ent = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (dispatch_en && alloc_ok[i]) begin
        wr_en[alloc_sel[i]]  = 1'b1;
        wr_ent[alloc_sel[i]] = disp[i];
      end
    end
  end

  // Issue picks from pre-edge state only; same-cycle wakeups issue next cycle.
  always_comb begin
    issue_sel    = '0;
    permit_issue = '0;
    issue_V1_out = '0;
    issue_V2_out = '0;
    if (issue_en && !reset) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        for (int e = 0; e < RS_SIZE; e++) begin
          if (!permit_issue[k] && ent_class(e) == 2'(k) && ent_q[e].busy && !ent_q[e].issued &&
              ent_q[e].T1 == '0 && ent_q[e].T2 == '0) begin
            permit_issue[k] = 1'b1;
            issue_sel[e]    = 1'b1;
            issue_V1_out[k] = ent_q[e].V1;
            issue_V2_out[k] = ent_q[e].V2;
          end
        end
      end
    end
  end

  always_comb begin
    RS_available_size = reset ? 3'd0 : avail_cnt;
    for (int i = 0; i < NUM_LANES; i++)
      RS_idx_test[i] = (!reset && alloc_ok[i]) ? 5'(alloc_sel[i]) : 5'd31;
  end

  for (genvar e = 0; e < RS_SIZE; e++) begin : g_ent
    rs_ent u_ent (
      .ent_q           (ent_q[e]),
      .issue_set       (issue_sel[e]),
      .complete_en     (complete_en),
      .cdb_tag         (CDB_tag),
      .cdb_value       (CDB_value),
      .execute_en      (execute_en),
      .execute_rob_tag (execute_rob_tag),
      .wr_en           (wr_en[e]),
      .wr_ent          (wr_ent[e]),
      .ent_d           (ent_d[e])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) ent_q <= '0;
    else       ent_q <= ent_d;
  end

  assign rs_entry_test = ent_q;
endmodule

// File: tb/tb_rs.sv
// Directed bench for rs: entry-state expectations queued at drive time, checked after the edge.
module tb_rs;
  import rs_pkg::*;

  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, dispatch_en, issue_en, execute_en, complete_en;
  logic [2:0][6:0]    opcode;
  logic [TW-1:0]      ROB_tail;
  logic [2:0][TW-1:0] tag1, tag2, ex_tag, cdb_tag;
  logic [2:0]         rdy1, rdy2, hit1, hit2;
  logic [2:0][31:0]   opa, opb, rob_v1, rob_v2, cdb_val;
  logic [2:0]         avail;
  logic [2:0][4:0]    idx;
  logic [2:0]         permit;
  logic [2:0][31:0]   iv1, iv2;
  RS_ENTRY [15:0]     ents;

  rs dut (
    .clk(clk), .reset(reset), .dispatch_en(dispatch_en), .opcode(opcode), .ROB_tail(ROB_tail),
    .MAP_TABLE_tag1(tag1), .MAP_TABLE_tag2(tag2), .MAP_TABLE_ready1(rdy1), .MAP_TABLE_ready2(rdy2),
    .MAP_TABLE_hit1(hit1), .MAP_TABLE_hit2(hit2), .OPA(opa), .OPB(opb), .ROB_V1(rob_v1),
    .ROB_V2(rob_v2), .issue_en(issue_en), .execute_en(execute_en), .execute_rob_tag(ex_tag),
    .complete_en(complete_en), .CDB_tag(cdb_tag), .CDB_value(cdb_val),
    .RS_available_size(avail), .RS_idx_test(idx), .permit_issue(permit),
    .issue_V1_out(iv1), .issue_V2_out(iv2), .rs_entry_test(ents)
  );

  typedef struct {
    string       nm;
    int          ent;
    int          fld;
    logic [31:0] exp;
  } sb_t;
  sb_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", nm, obs, exp);
    end
  endtask

  // fld: 0 busy 1 issued 2 T 3 T1 4 T2 5 V1 6 V2 7 any-nonzero
  function automatic logic [31:0] fld(input int e, input int f);
    case (f)
      0:       return 32'(ents[e].busy);
      1:       return 32'(ents[e].issued);
      2:       return 32'(ents[e].T);
      3:       return 32'(ents[e].T1);
      4:       return 32'(ents[e].T2);
      5:       return ents[e].V1;
      6:       return ents[e].V2;
      default: return 32'(ents[e] != '0);
    endcase
  endfunction

  task automatic push(input string nm, input int e, input int f, input logic [31:0] exp);
    sb_t it;
    it.nm = $sformatf("%s_e%0d_f%0d", nm, e, f);
    it.ent = e; it.fld = f; it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic exp_ent(input string nm, input int e, input logic iss, input logic [31:0] t,
                         input logic [31:0] t1, input logic [31:0] t2,
                         input logic [31:0] v1, input logic [31:0] v2);
    push(nm, e, 0, 1);  push(nm, e, 1, 32'(iss)); push(nm, e, 2, t);
    push(nm, e, 3, t1); push(nm, e, 4, t2);       push(nm, e, 5, v1); push(nm, e, 6, v2);
  endtask

  task automatic drain();
    sb_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      chk(it.nm, fld(it.ent, it.fld), it.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dispatch_en = 0; issue_en = 0; execute_en = 0; complete_en = 0;
    opcode[0] = OP_LD; opcode[1] = OP_ST; opcode[2] = OP_ADDI;
    ROB_tail = 4'd3; tag1 = '0; tag2 = '0; rdy1 = '0; rdy2 = '0; hit1 = '0; hit2 = '0;
    opa = '0; opb = '0; rob_v1 = '0; rob_v2 = '0; ex_tag = '0; cdb_tag = '0; cdb_val = '0;
    for (int i = 0; i < 3; i++) begin
      opa[i] = 32'(11 + i); opb[i] = 32'(14 + i);
    end
  endtask

  task automatic do_reset(input string nm);
    idle();
    reset = 1;
    tick();
    tick();
    issue_en = 1;
    #1;
    chk({nm, "_permit"}, 32'(permit), 0);
    chk({nm, "_idx"}, 32'(idx), 32'({5'd31, 5'd31, 5'd31}));
    for (int e = 0; e < 16; e++) push(nm, e, 7, 0);
    drain();
    issue_en = 0;
    reset = 0;
    #1;
  endtask

  initial begin
    reset = 1;
    idle();

    // Phase A: fill LOAD/STORE partitions from unrenamed operands.
    do_reset("rstA");
    chk("avail_no_disp", 32'(avail), 3);
    dispatch_en = 1;
    for (int g = 0; g < 3; g++) begin
      #1;
      chk($sformatf("A_avail%0d", g), 32'(avail), 3);
      chk($sformatf("A_idx%0d", g), 32'(idx), 32'({5'(6 + g), 5'(3 + g), 5'(g)}));
      for (int i = 0; i < 3; i++) exp_ent("A", 3 * i + g, 0, 4 + i, 0, 0, 11 + i, 14 + i);
      tick();
      drain();
    end
    #1;
    chk("A_full_avail", 32'(avail), 0);
    chk("A_full_idx", 32'(idx), 32'({5'd31, 5'd31, 5'd31}));
    push("A_full", 9, 7, 0);
    exp_ent("A_keep", 2, 0, 4, 0, 0, 11, 14);
    tick();
    drain();

    // Phase B: ROB-ready operands, tail wrap skipping tag 0.
    do_reset("rstB");
    hit1 = 3'b111; hit2 = 3'b111; rdy1 = 3'b111; rdy2 = 3'b111; ROB_tail = 4'd13;
    for (int i = 0; i < 3; i++) begin
      rob_v1[i] = 32'(21 + i); rob_v2[i] = 32'(24 + i);
    end
    dispatch_en = 1;
    exp_ent("B", 0, 0, 14, 0, 0, 21, 24);
    exp_ent("B", 3, 0, 15, 0, 0, 22, 25);
    exp_ent("B", 6, 0, 1,  0, 0, 23, 26);
    tick();
    drain();

    // Phase C: pending producers, execute free, CDB wakeup, then issue.
    do_reset("rstC");
    hit1 = 3'b111; hit2 = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tag1[i] = 4'(1 + i); tag2[i] = 4'(4 + i); rob_v1[i] = 32'd99; rob_v2[i] = 32'd98;
    end
    dispatch_en = 1;
    for (int g = 0; g < 3; g++) begin
      ROB_tail = 4'(3 + 3 * g);
      #1;
      for (int i = 0; i < 3; i++) exp_ent("C", 3 * i + g, 0, 4 + 3 * g + i, 1 + i, 4 + i, 0, 0);
      tick();
      drain();
    end
    dispatch_en = 0; issue_en = 1;
    #1;
    chk("C_permit_pending", 32'(permit), 0);
    push("C_noiss", 0, 1, 0);
    tick();
    drain();
    issue_en = 0; execute_en = 1;
    for (int i = 0; i < 3; i++) ex_tag[i] = 4'(4 + i);
    for (int i = 0; i < 3; i++) push("C_exec", 3 * i, 7, 0);
    exp_ent("C_exec_keep", 1, 0, 7, 1, 4, 0, 0);
    tick();
    drain();
    execute_en = 0;
    #1;
    chk("C_realloc_idx", 32'(idx), 32'({5'd6, 5'd3, 5'd0}));
    complete_en = 1;
    for (int i = 0; i < 3; i++) begin
      cdb_tag[i] = 4'(4 + i); cdb_val[i] = 32'(31 + i);
    end
    for (int i = 0; i < 3; i++) begin
      exp_ent("C_cdb", 3 * i + 1, 0, 7 + i, 1 + i, 0, 0, 31 + i);
      exp_ent("C_cdb", 3 * i + 2, 0, 10 + i, 1 + i, 0, 0, 31 + i);
    end
    tick();
    drain();
    // Duplicate tag 1 on lanes 0 and 1: lane 0 must win.
    issue_en = 1;
    cdb_tag[0] = 4'd1; cdb_val[0] = 32'd41;
    cdb_tag[1] = 4'd1; cdb_val[1] = 32'd77;
    cdb_tag[2] = 4'd2; cdb_val[2] = 32'd42;
    #1;
    chk("C_permit_same_cycle", 32'(permit), 0);
    exp_ent("C_dup", 1, 0, 7, 0, 0, 41, 31);
    exp_ent("C_dup", 4, 0, 8, 0, 0, 42, 32);
    exp_ent("C_dup_alu", 7, 0, 9, 3, 0, 0, 33);
    tick();
    drain();
    complete_en = 0;
    #1;
    chk("C_permit_woken", 32'(permit), 3);
    chk("C_iv1_ld", iv1[0], 41);
    chk("C_iv2_ld", iv2[0], 31);
    chk("C_iv1_st", iv1[1], 42);
    chk("C_iv2_st", iv2[1], 32);
    chk("C_iv1_alu", iv1[2], 0);
    push("C_iss", 1, 1, 1);
    push("C_iss", 4, 1, 1);
    push("C_notiss", 2, 1, 0);
    tick();
    drain();
    #1;
    chk("C_permit_next", 32'(permit), 3);
    issue_en = 0;

    // Phase D: ready entries issue once.
    do_reset("rstD");
    dispatch_en = 1;
    tick();
    dispatch_en = 0; issue_en = 1;
    #1;
    chk("D_permit", 32'(permit), 7);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("D_iv1_%0d", k), iv1[k], 32'(11 + k));
      chk($sformatf("D_iv2_%0d", k), iv2[k], 32'(14 + k));
    end
    for (int k = 0; k < 3; k++) push("D_iss", 3 * k, 1, 1);
    tick();
    drain();
    #1;
    chk("D_no_reissue", 32'(permit), 0);
    chk("D_v1_zero", iv1[0], 0);
    issue_en = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/rs.md
Name: rs

Overview:
- Unified reservation station for a 3-wide out-of-order core (P6 style), sitting between dispatch/rename and the functional units.
- Holds up to 16 in-flight instructions in three class partitions, captures operands from the register file, ROB or CDB, and issues ready instructions.
- Frees entries at execute; wakes up waiting operands on CDB broadcast.

Parameters:
- ROB_SIZE, 16 (from the `ROB_SIZE define), ROB depth. Tag width TW = $clog2(ROB_SIZE). Tag 0 is reserved and means "no pending producer".
- RS_SIZE, 16, total entries. Partitions: LOAD 0-2, STORE 3-5, ALU 6-15.

Ports:
- clk in 1 clock
- reset in 1 synchronous active-high reset
- dispatch_en in 1 dispatch group valid
- opcode[2:0] in 7 each, RV32 opcode per slot
- ROB_tail in TW, current ROB tail
- MAP_TABLE_tag1/tag2[2:0] in TW each, producer tags for rs1/rs2
- MAP_TABLE_ready1/ready2 in 3, producer value ready in ROB
- MAP_TABLE_hit1/hit2 in 3, operand renamed
- OPA/OPB[2:0] in 32 each, architectural register-file value (or PC/IMM)
- ROB_V1/ROB_V2[2:0] in 32 each, ROB value
- issue_en in 1 issue stage enable
- execute_en in 1, execute_rob_tag[2:0] in TW each
- complete_en in 1, CDB_tag[2:0] in TW each, CDB_value[2:0] in 32 each
- RS_available_size out 3, count 0-3
- RS_idx_test[2:0] out 5 each, allocated entry per slot
- permit_issue out 3, issue_V1_out/issue_V2_out[2:0] out 32 each
- rs_entry_test out RS_ENTRY[15:0], entry array; RS_ENTRY is the shared packed struct {busy, issued, opcode[6:0], T, T1, T2, V1[31:0], V2[31:0]}

Behaviour:
- Reset (sync, highest priority): every entry field cleared to 0. Outputs permit_issue=0, issue_V*_out=0, RS_idx_test=31.
- Class: `RV32_LOAD → LOAD, `RV32_STORE → STORE, anything else → ALU.
- Allocation (combinational):
  - Slots are processed in order 0,1,2. Each slot takes the lowest-index non-busy entry of its class not already taken by an earlier slot.
  - RS_available_size = number of leading slots that can allocate (stop at the first failing slot).
  - When dispatch_en=0, RS_available_size still reports the count.
  - RS_idx_test[i] = entry index for i < RS_available_size, else 31.
- Dispatch (posedge, dispatch_en=1): slots 0..RS_available_size-1 are written.
  - busy=1, issued=0, opcode.
  - T = ROB_tail+i+1 mod ROB_SIZE, skipping 0 (0 wraps to 1).
  - Operand n, hit=0: Vn=OPA/OPB, Tn=0.
  - Operand n, hit=1 and ready=1: Vn=ROB_Vn, Tn=0.
  - Operand n, hit=1 and ready=0: Tn=map tag, Vn=0.
- Issue (combinational, issue_en=1):
  - Output k (0=LOAD, 1=STORE, 2=ALU) picks the lowest-index entry of class k with busy=1, issued=0, T1=0, T2=0.
  - permit_issue[k]=1, V1/V2 driven to issue_V*_out[k]. Otherwise permit_issue[k]=0 and values 0.
  - On the clock edge the chosen entry sets issued=1.
- Execute (posedge, execute_en=1): any busy entry whose T equals a nonzero execute_rob_tag[j] is cleared to all zeros. A freed entry becomes allocatable the next cycle.
- Complete (posedge, complete_en=1):
  - For each busy entry and each j, if Tn≠0 and Tn==CDB_tag[j], then Vn=CDB_value[j], Tn=0.
  - CDB_tag 0 is ignored.
- Simultaneous events:
  - Issue selection uses the pre-edge state; a CDB wakeup in the same cycle makes the entry issuable next cycle.
  - Execute-free and dispatch never target the same entry in one cycle.
  - Duplicate CDB tags: the lowest j wins.

Optional Feature:
- RS_CDB_BYPASS_EN defined: at dispatch, if an operand would store Tn = map tag and complete_en=1 with a matching nonzero CDB_tag[j], the entry instead captures Vn=CDB_value[j] and Tn=0.
- Undefined: the map tag is stored unchanged. The upstream map table must already report ready for a same-cycle broadcast.

Test Plan:
- Reset, then dispatch {LOAD, STORE, ADDI}, ROB_tail=3, hit=0, OPA=11/12/13, OPB=14/15/16 → entries 0/3/6 get V1=11/12/13, V2=14/15/16, T=4/5/6, RS_available_size=3.
  - Repeat → entries 1/4/7, then 2/5/8.
  - 4th cycle: RS_available_size=0, RS_idx=31, entry 9 stays empty.
- Reset, hit=ready=111, ROB_V1=21/22/23, ROB_V2=24/25/26 → entries 0/3/6 get those values, T1=T2=0.
- Reset, hit=111, ready=000, tag1=1/2/3, tag2=4/5/6, three dispatches → T1/T2 stored, V=0.
  - Then issue_en → permit_issue=000.
- execute_en, execute_rob_tag=4/5/6 → entries 0/3/6 busy=0, all fields 0.
- complete_en, CDB_tag=4/5/6, CDB_value=31/32/33 → entries with T2=4/5/6 get V2=31/32/33 and T2=0; T1 (1/2/3) unchanged.
- Ready entries (hit=0) with issue_en=1 → permit_issue=111 and issue_V1_out=11/12/13 from entries 0/3/6. Next cycle the same entries are not reissued.
